// File: rtl/scoreboard_ctrl_pkg.sv
// Shared types and defaults for the measurement-run scoreboard controller.
// Holds the FSM encoding, default widths/timeout and the drain-timer width helper.
package scoreboard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_LEN_W  = 24;
  localparam int DEF_ERR_W  = 16;
  localparam int DEF_TO_CYC = 64;

  // The drain timer counts 0 .. to_cyc-2, so $clog2(to_cyc) bits suffice.
  function automatic int timer_width(input int to_cyc);
    return (to_cyc <= 2) ? 1 : $clog2(to_cyc);
  endfunction

  localparam int DEF_TIMER_W = timer_width(DEF_TO_CYC);

endpackage

// File: rtl/scoreboard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds once it reaches limit.
// Used for issued, received and mismatch counts.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != limit)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Measurement-run controller: issues i_len samples, collects results and
// mismatches, then finishes on full receipt, drain timeout or abort.
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_result_valid,
  input  logic             i_mismatch,
  output logic             o_issue,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_aborted,
  output logic [LEN_W-1:0] o_issued,
  output logic [LEN_W-1:0] o_received,
  output logic [ERR_W-1:0] o_err_ctr,
  output state_t           o_state
);

  localparam int TW = timer_width(TO_CYC);

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q;
  logic [TW-1:0]    timer;
  logic             timeout_q, aborted_q;
  logic             busy, start_ok, abort_ev, to_ev;
  logic             rcv_acc, err_acc, rcv_last;

  // Handshake: i_result_valid is a single-cycle strobe with no back-pressure;
  // i_mismatch is meaningful only in a cycle where i_result_valid is high.
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign start_ok = (state == S_IDLE) && i_start;
  assign rcv_acc  = busy && i_result_valid;
  assign err_acc  = rcv_acc && i_mismatch && (o_received != len_q);
  // True when the received count is (or becomes, this cycle) the full length.
  assign rcv_last = (o_received == len_q) ||
                    (rcv_acc && (o_received == len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    abort_ev = 1'b0;
    to_ev    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_d = (i_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (i_abort) begin
          state_d  = S_IDLE;
          abort_ev = 1'b1;
        end else if (o_issued == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          state_d  = S_IDLE;
          abort_ev = 1'b1;
        end else if (rcv_last) begin
          state_d = S_DONE;
        end else if (!i_result_valid && (timer == TW'(TO_CYC - 2))) begin
          state_d = S_DONE;
          to_ev   = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_issue = (state == S_RUN);
    o_busy  = busy;
    o_done  = (state == S_DONE);
    o_state = state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      len_q <= '0;
    else if (start_ok) len_q <= i_len;
  end

  // Quiet-cycle timer: the timeout lands TO_CYC edges after the last result
  // (or after the final issue when nothing arrives in DRAIN). Needs TO_CYC >= 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if ((state != S_DRAIN) || i_result_valid) begin
      timer <= '0;
    end else if (timer != TW'(TO_CYC - 2)) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
    end else if (start_ok) begin
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (abort_ev) aborted_q <= 1'b1;
      if (to_ev)    timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
  assign o_aborted = aborted_q;

  sat_counter #(.W(LEN_W)) u_issued (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_ok),
    .inc     (state == S_RUN),
    .limit   (len_q),
    .count   (o_issued)
  );

  sat_counter #(.W(LEN_W)) u_received (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_ok),
    .inc     (rcv_acc),
    .limit   (len_q),
    .count   (o_received)
  );

  sat_counter #(.W(ERR_W)) u_err (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_ok),
    .inc     (err_acc),
    .limit   ({ERR_W{1'b1}}),
    .count   (o_err_ctr)
  );

endmodule
